aq_axi_slave_ram64: RTL and testbench
=====================================

Name: aq_axi_slave_ram64

Overview:
AXI4 slave responder with an internal 64-bit-wide RAM. It is the far end of the AXI4 master used by the memcpy engine: it accepts that master's INCR write bursts and serves its read bursts. Its first use is as the memory target in memcpy simulation and self-test builds; it is also usable as on-chip scratch RAM. The write and read channels are independent and may be active at the same time.

Parameters:
MEM_AW, 12, log2 of RAM depth in 64-bit words (default 4096 words = 32 KiB); the address map wraps modulo 2^(MEM_AW+3) bytes.

Ports:
S_AXI_ACLK  in  1  single clock; all logic on rising edge
ARESETN  in  1  reset, synchronous, active-low
S_AXI_AWID  in  1  write burst ID
S_AXI_AWADDR  in  32  write start byte address
S_AXI_AWLEN  in  8  beats minus 1
S_AXI_AWSIZE  in  3  must be 3 (8 bytes)
S_AXI_AWBURST  in  2  must be 2'b01 (INCR)
S_AXI_AWVALID  in  1  address valid
S_AXI_AWREADY  out  1  address accepted
S_AXI_WDATA  in  64  write data
S_AXI_WSTRB  in  8  byte enables
S_AXI_WLAST  in  1  last beat marker
S_AXI_WVALID  in  1  data valid
S_AXI_WREADY  out  1  data accepted
S_AXI_BID  out  1  response ID
S_AXI_BRESP  out  2  2'b00 OKAY or 2'b10 SLVERR
S_AXI_BVALID  out  1  response valid
S_AXI_BREADY  in  1  response accepted
S_AXI_ARID  in  1  read burst ID
S_AXI_ARADDR  in  32  read start byte address
S_AXI_ARLEN  in  8  beats minus 1
S_AXI_ARSIZE  in  3  must be 3
S_AXI_ARBURST  in  2  must be 2'b01
S_AXI_ARVALID  in  1  address valid
S_AXI_ARREADY  out  1  address accepted
S_AXI_RID  out  1  read ID
S_AXI_RDATA  out  64  read data
S_AXI_RRESP  out  2  OKAY or SLVERR
S_AXI_RLAST  out  1  last beat marker
S_AXI_RVALID  out  1  data valid
S_AXI_RREADY  in  1  data accepted

Behaviour:
- Not present: LOCK, CACHE, PROT, QOS and USER signals. The master's outputs for these stay unconnected; BUSER and RUSER on the master are tied to 0 at integration.
- Reset (ARESETN low at a clock edge): both FSMs go to IDLE. All outputs read 0, including AWREADY and ARREADY. RAM contents are preserved. A reset in the middle of a burst abandons it with no response.
- Word index: addr[MEM_AW+2:3]; addr[2:0] is ignored. The index increments by 1 per beat and wraps from 2^MEM_AW-1 to 0.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY, latch ID, index and AWLEN, clear the beat counter and set err = (AWSIZE!=3 | AWBURST!=2'b01).
  - W_DATA: AWREADY=0, WREADY=1. On each WVALID&WREADY:
    - If err=0, write byte k of WDATA to RAM when WSTRB[k]=1.
    - Set err if WLAST != (count==len).
    - If count==len, go to W_RESP; otherwise increment count and index.
  - The burst always ends after len+1 beats. WLAST affects only err. If err=1, data is accepted but the RAM is not written.
  - W_RESP: BVALID=1, BID=latched ID, BRESP = err ? 2'b10 : 2'b00. These hold until BREADY; then go to W_IDLE with BVALID=0 on the following cycle.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch ID and len, set err as for writes, register RDATA <= err ? 0 : mem[idx], and go to R_DATA. RVALID rises the cycle after the AR handshake (1-cycle latency).
  - R_DATA: ARREADY=0, RVALID=1, RLAST=(count==len), RRESP = err ? 2'b10 : 2'b00.
  - On RVALID&RREADY with a non-last beat: load RDATA from mem[idx+1] and keep RVALID=1, giving back-to-back beats at 1 beat per cycle.
  - On RVALID&RREADY with the last beat: RVALID=0 and go to R_IDLE.
  - RVALID low: RDATA, RLAST and RRESP are don't-care.
  - RREADY low: RDATA, RLAST and RRESP hold stable.
- RAM is a synchronous single-write, single-read array and must be BRAM-inferable.
- Same word read and written in the same cycle: the read returns the old data (read-before-write).
- Counter rules: beat counter is 8 bits, so the maximum burst is 256 beats. AWLEN=0 or ARLEN=0 is a single beat with LAST on that beat.
- Simultaneous AW and AR handshakes in the same cycle are both accepted. There is no ordering between the write and read channels.

Test Plan:
- Write with AWADDR=0x100, AWLEN=3, WSTRB=0xFF, data 0x11..0x44 -> 4 WREADY beats, then BVALID with BRESP=0 and BID=AWID. A following read with ARADDR=0x100, ARLEN=3 and RREADY held high -> RVALID 1 cycle after AR, 4 consecutive beats 0x11..0x44, RLAST on beat 4, RRESP=0.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then 0x0 with WSTRB=0x0F -> readback 0xFFFF_FFFF_0000_0000.
- Wrap with MEM_AW=12: 2-beat write at 0x7FF8 -> the second beat lands at word 0, and readback from 0x0 returns it.
- Error cases:
  - AWBURST=2'b10 -> all beats accepted, BRESP=2'b10, RAM unchanged.
  - WLAST early on beat 2 of 4 -> BRESP=2'b10.
  - ARSIZE=2 -> RRESP=2'b10 and RDATA=0 on every beat.
- Backpressure and concurrency:
  - Toggle RREADY randomly during a 256-beat read -> RDATA is stable while stalled and all 256 words are correct.
  - Hold BREADY low for 10 cycles -> BVALID is held and AWREADY stays 0.
  - Issue read and write bursts concurrently -> both complete.
- Assert ARESETN low in the middle of a write burst -> next cycle all outputs are 0. After release, AWREADY=1 and previously written RAM data reads back intact.

Source files
------------

// File: rtl/aq_axi_slave_ram64.sv
// rtl/aq_axi_slave_ram64.sv - AXI4 INCR burst slave backed by a 64-bit synchronous RAM
// Independent write (AW/W/B) and read (AR/R) FSMs sharing one single-write, single-read array.
module aq_axi_slave_ram64 #(
  parameter int MEM_AW = 12
) (
  input  logic        S_AXI_ACLK,
  input  logic        ARESETN,
  input  logic        S_AXI_AWID,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [63:0] S_AXI_WDATA,
  input  logic [7:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic        S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic        S_AXI_ARID,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic        S_AXI_RID,
  output logic [63:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [63:0] mem [DEPTH];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic              active;
  logic              w_id, w_err, r_id, r_err;
  logic [MEM_AW-1:0] w_idx, r_idx, rd_addr;
  logic [7:0]        w_len, w_cnt, r_len, r_cnt;
  logic [63:0]       r_q;
  logic              aw_hs, w_hs, ar_hs, r_hs, w_last_beat, r_last_beat, rd_en;
  logic              aw_bad, ar_bad;

  // Handshakes are derived from state rather than the ready outputs to keep the comb logic acyclic.
  assign aw_hs       = (w_state == W_IDLE) && active && S_AXI_AWVALID;
  assign w_hs        = (w_state == W_DATA) && S_AXI_WVALID;
  assign ar_hs       = (r_state == R_IDLE) && active && S_AXI_ARVALID;
  assign r_hs        = (r_state == R_DATA) && S_AXI_RREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);
  assign aw_bad      = (S_AXI_AWSIZE != 3'd3) || (S_AXI_AWBURST != 2'b01);
  assign ar_bad      = (S_AXI_ARSIZE != 3'd3) || (S_AXI_ARBURST != 2'b01);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      active  <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      active  <= 1'b1;
    end
  end

  always_comb begin
    w_next = w_state;
    r_next = r_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!ARESETN) begin
      w_id  <= 1'b0;
      w_err <= 1'b0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      r_id  <= 1'b0;
      r_err <= 1'b0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      if (aw_hs) begin
        w_id  <= S_AXI_AWID;
        w_idx <= S_AXI_AWADDR[MEM_AW+2:3];
        w_len <= S_AXI_AWLEN;
        w_cnt <= '0;
        w_err <= aw_bad;
      end else if (w_hs) begin
        if (S_AXI_WLAST != w_last_beat) w_err <= 1'b1;
        if (!w_last_beat) begin
          w_cnt <= w_cnt + 8'd1;
          w_idx <= w_idx + 1'b1;
        end
      end
      if (ar_hs) begin
        r_id  <= S_AXI_ARID;
        r_idx <= S_AXI_ARADDR[MEM_AW+2:3];
        r_len <= S_AXI_ARLEN;
        r_cnt <= '0;
        r_err <= ar_bad;
      end else if (r_hs && !r_last_beat) begin
        r_cnt <= r_cnt + 8'd1;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // The read port fetches the first word at AR time and the next word on each accepted beat.
  assign rd_en   = ar_hs || (r_hs && !r_last_beat);
  assign rd_addr = ar_hs ? S_AXI_ARADDR[MEM_AW+2:3] : r_idx + 1'b1;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!ARESETN) r_q <= '0;
    else if (rd_en) r_q <= mem[rd_addr];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (ARESETN && w_hs && !w_err) begin
      for (int k = 0; k < 8; k++) begin
        if (S_AXI_WSTRB[k]) mem[w_idx][8*k +: 8] <= S_AXI_WDATA[8*k +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = active && (w_state == W_IDLE);
  assign S_AXI_WREADY  = (w_state == W_DATA);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BID     = w_id;
  assign S_AXI_BRESP   = ((w_state == W_RESP) && w_err) ? 2'b10 : 2'b00;
  assign S_AXI_ARREADY = active && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RID     = r_id;
  assign S_AXI_RDATA   = r_err ? 64'd0 : r_q;
  assign S_AXI_RRESP   = ((r_state == R_DATA) && r_err) ? 2'b10 : 2'b00;
  assign S_AXI_RLAST   = (r_state == R_DATA) && r_last_beat;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[31:MEM_AW+3], S_AXI_AWADDR[2:0],
                              S_AXI_ARADDR[31:MEM_AW+3], S_AXI_ARADDR[2:0]};

endmodule

// File: tb/tb_aq_axi_slave_ram64.sv
// tb/tb_aq_axi_slave_ram64.sv - directed/randomized bench for aq_axi_slave_ram64
// Reference model is a plain word array updated per accepted write beat.
module tb_aq_axi_slave_ram64;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        awid, awvalid, wlast, wvalid, bready, arid, arvalid, rready;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic [63:0] wdata;
  logic        awready, wready, bid, bvalid, arready, rid, rlast, rvalid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  aq_axi_slave_ram64 #(.MEM_AW(12)) dut (
    .S_AXI_ACLK(clk), .ARESETN(resetn),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];
  logic [75:0] all_out;

  assign all_out = {awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid};

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr, input int beat);
    return (int'(addr[14:3]) + beat) % DEPTH;
  endfunction

  function automatic void model_write(input int w, input logic [63:0] d, input logic [7:0] s);
    for (int k = 0; k < 8; k++)
      if (s[k]) ref_mem[w][8*k +: 8] = d[8*k +: 8];
  endfunction

  // early < 0: WLAST on the final beat; otherwise WLAST only on beat index 'early'.
  task automatic do_write(input logic id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int early, input int bstall);
    int  n;
    bit  err;
    err = (size != 3'd3) || (burst != 2'b01);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (awready !== 1'b1 && n < 50);
    if (awready !== 1'b1) chk("aw_timeout", 80'(awready), 80'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i];
      wlast = (early >= 0) ? (i == early) : (i == len);
      wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (wready !== 1'b1 && n < 50);
      if (wready !== 1'b1) chk("w_timeout", 80'(wready), 80'd1);
      if (!err) model_write(word_of(addr, i), wbuf[i], sbuf[i]);
      if (wlast != (i == len)) err = 1'b1;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b0;
    for (int c = 0; c < bstall; c++) begin
      @(negedge clk);
      chk("bvalid_hold", 80'(bvalid), 80'd1);
      chk("awready_stall", 80'(awready), 80'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bvalid !== 1'b1 && n < 50);
    chk("bvalid", 80'(bvalid), 80'd1);
    chk("bid", 80'(bid), 80'(id));
    chk("bresp", 80'(bresp), err ? 80'd2 : 80'd0);
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    chk("bvalid_drop", 80'(bvalid), 80'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input bit rrand);
    int  n, beat, cyc;
    bit  err;
    logic [63:0] exp;
    err = (size != 3'd3) || (burst != 2'b01);
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (arready !== 1'b1 && n < 50);
    if (arready !== 1'b1) chk("ar_timeout", 80'(arready), 80'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    rready = rrand ? 1'($urandom) : 1'b1;
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 4 * (len + 1) + 40) begin
      @(negedge clk);
      cyc++;
      exp = err ? 64'd0 : ref_mem[word_of(addr, beat)];
      chk("rvalid", 80'(rvalid), 80'd1);
      chk("rdata", 80'(rdata), 80'(exp));
      chk("rlast", 80'(rlast), 80'(beat == len));
      chk("rresp", 80'(rresp), err ? 80'd2 : 80'd0);
      chk("rid", 80'(rid), 80'(id));
      if (rready) beat++;
      @(posedge clk); #1 rready = rrand ? 1'($urandom) : 1'b1;
    end
    if (beat <= len) chk("r_timeout", 80'(beat), 80'(len + 1));
    rready = 1'b0;
    @(negedge clk);
    chk("rvalid_drop", 80'(rvalid), 80'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    resetn = 1'b0;
    {awid, awvalid, wlast, wvalid, bready, arid, arvalid, rready} = '0;
    {awaddr, araddr, awlen, arlen, wstrb, awsize, arsize, awburst, arburst, wdata} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 80'(all_out), 80'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    // basic 4-beat burst and readback
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'h11 * (i + 1); sbuf[i] = 8'hFF; end
    do_write(1'b1, 32'h100, 3, 3'd3, 2'b01, -1, 0);
    do_read(1'b1, 32'h100, 3, 3'd3, 2'b01, 1'b0);

    // partial strobe
    wbuf[0] = '1; sbuf[0] = 8'hFF;
    do_write(1'b0, 32'h0, 0, 3'd3, 2'b01, -1, 0);
    wbuf[0] = '0; sbuf[0] = 8'h0F;
    do_write(1'b1, 32'h0, 0, 3'd3, 2'b01, -1, 0);
    do_read(1'b0, 32'h0, 0, 3'd3, 2'b01, 1'b0);
    chk("partial_word", 80'(rdata), 80'(64'hFFFF_FFFF_0000_0000));

    // wrap from the top word to word 0
    for (int i = 0; i < 2; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    do_write(1'b0, 32'h7FF8, 1, 3'd3, 2'b01, -1, 0);
    do_read(1'b1, 32'h0, 0, 3'd3, 2'b01, 1'b0);
    do_read(1'b0, 32'h7FF8, 1, 3'd3, 2'b01, 1'b0);

    // prefill a 256-word region
    for (int i = 0; i < 256; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    do_write(1'b1, 32'h1000, 255, 3'd3, 2'b01, -1, 0);

    // error cases
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    do_write(1'b1, 32'h100, 3, 3'd3, 2'b10, -1, 0);
    do_read(1'b0, 32'h100, 3, 3'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
    do_write(1'b0, 32'h1040, 3, 3'd3, 2'b01, 1, 0);
    do_read(1'b1, 32'h1040, 3, 3'd3, 2'b01, 1'b0);
    do_write(1'b1, 32'h1080, 1, 3'd2, 2'b01, -1, 0);
    do_read(1'b0, 32'h1080, 1, 3'd3, 2'b01, 1'b0);
    do_read(1'b1, 32'h1000, 3, 3'd2, 2'b01, 1'b0);

    // full-length read under random backpressure, then B-channel stall
    do_read(1'b1, 32'h1000, 255, 3'd3, 2'b01, 1'b1);
    wbuf[0] = {$urandom, $urandom}; sbuf[0] = 8'hFF;
    do_write(1'b0, 32'h1100, 0, 3'd3, 2'b01, -1, 10);
    do_read(1'b0, 32'h1100, 0, 3'd3, 2'b01, 1'b0);

    // concurrent channels on disjoint regions
    for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'($urandom); end
    fork
      do_write(1'b1, 32'h2000, 15, 3'd3, 2'b01, -1, 0);
      do_read(1'b0, 32'h1200, 31, 3'd3, 2'b01, 1'b1);
    join
    do_read(1'b1, 32'h2000, 15, 3'd3, 2'b01, 1'b1);

    // randomized bursts inside the prefilled region
    for (int r = 0; r < 6; r++) begin
      int len;
      base = 512 + int'($urandom_range(0, 239));
      len = int'($urandom_range(0, 15));
      for (int i = 0; i <= len; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'($urandom); end
      do_write(1'($urandom), 32'(base * 8), len, 3'd3, 2'b01, -1, int'($urandom_range(0, 3)));
      do_read(1'($urandom), 32'(base * 8), len, 3'd3, 2'b01, 1'b1);
    end

    // reset in the middle of a write burst
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    awid = 1'b1; awaddr = 32'h3000; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    chk("rst_aw_ready", 80'(awready), 80'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = wbuf[i]; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      @(negedge clk);
      chk("rst_w_ready", 80'(wready), 80'd1);
      model_write(word_of(32'h3000, i), wbuf[i], 8'hFF);
      @(posedge clk); #1;
    end
    wdata = wbuf[2];
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midburst_reset_outputs", 80'(all_out), 80'd0);
    @(posedge clk); #1 wvalid = 1'b0; resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_awready", 80'(awready), 80'd1);
    @(posedge clk); #1;
    do_read(1'b0, 32'h3000, 1, 3'd3, 2'b01, 1'b0);
    do_read(1'b1, 32'h100, 3, 3'd3, 2'b01, 1'b0);
    do_read(1'b0, 32'h1000, 63, 3'd3, 2'b01, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
